fsk16_demap: RTL

- Receive-side 16FSK symbol demapper; the inverse of the transmit frequency mapper.
- Accepts one signed 8-bit frequency code per symbol from the frequency estimator, hard-decides the nearest of the 16 grid points (-30..+30 MHz, step 4), and buffers the 4-bit symbol.
- Serializes each symbol back to the 2-bit data stream, high pair first, one pair per clk_load cycle, so the output bit order matches the transmitter input.
- Reports off-grid and overflow statistics for link diagnostics.

---
 rtl/fsk16_pkg.sv | 36 +++
 rtl/fsk16_demap_if.sv | 24 ++
 rtl/fsk16_sym_fifo.sv | 53 +++++
 rtl/fsk16_demap.sv | 105 ++++++++++
 4 files changed

// File: rtl/fsk16_pkg.sv
// Shared 16FSK grid constants, symbol type and the hard-decision demapper.
package fsk16_pkg;

  localparam int F_MIN  = -30;
  localparam int F_STEP = 4;
  localparam int N_SYM  = 16;
  localparam int FREQ_W = 8;

  typedef logic [3:0] sym_t;

  typedef struct packed {
    sym_t sym;
    logic off_grid;
  } demap_t;

  // Nearest-grid-point decision. Shifting the code by half a step above
  // F_MIN turns each decision cell into an aligned group of F_STEP codes.
  // That makes the symbol a plain bit slice and boundary codes round up.
  function automatic demap_t freq_to_sym(input logic signed [FREQ_W-1:0] freq);
    logic signed [FREQ_W:0] off;
    demap_t                 res;
    off = {freq[FREQ_W-1], freq} + (FREQ_W+1)'(F_STEP / 2 - F_MIN);
    if (off[FREQ_W]) begin
      res.sym      = '0;
      res.off_grid = 1'b1;
    end else if (off > (FREQ_W+1)'(N_SYM * F_STEP - 1)) begin
      res.sym      = '1;
      res.off_grid = 1'b1;
    end else begin
      res.sym      = off[5:2];
      res.off_grid = (off[1:0] != 2'(F_STEP / 2));
    end
    return res;
  endfunction

endpackage

// File: rtl/fsk16_demap_if.sv
// Frequency-estimate input and serialized data/statistics output bundle.
interface fsk16_demap_if #(parameter int ERR_W = 8);
  import fsk16_pkg::*;

  logic [FREQ_W-1:0] freq_in;
  logic              freq_valid;
  logic              clr_stat;
  logic [1:0]        dataout;
  logic              dout_valid;
  sym_t              sym_out;
  logic              overflow;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output freq_in, freq_valid, clr_stat,
    input  dataout, dout_valid, sym_out, overflow, err_cnt
  );

  modport slave (
    input  freq_in, freq_valid, clr_stat,
    output dataout, dout_valid, sym_out, overflow, err_cnt
  );

endinterface

// File: rtl/fsk16_sym_fifo.sv
// Small show-ahead symbol FIFO; pointers carry one extra wrap bit.
module fsk16_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk_load,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A full FIFO still takes a write when the same edge frees a slot.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer advance on accepted writes and reads.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (rd_en) rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_load or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk_load) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/fsk16_demap.sv
// 16FSK receive demapper: decision, symbol buffering, 2-bit serializer, stats.
module fsk16_demap import fsk16_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic         clk_load,
  input  logic         rst,
  fsk16_demap_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;

  demap_t           dec;
  sym_t             head;
  logic             fifo_full, fifo_empty, pop, drop;
  logic [1:0]       state_q, state_d;
  sym_t             sym_q, sym_d;
  logic [1:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [ERR_W-1:0] err_q, err_d;

  assign dec  = freq_to_sym(bus.freq_in);
  // The head may leave whenever the low pair of the previous symbol is not still pending.
  assign pop  = !fifo_empty && (state_q != ST_HI);
  assign drop = bus.freq_valid && fifo_full && !pop;

  fsk16_sym_fifo #(.DEPTH(FIFO_DEPTH), .W(4)) u_fifo (
    .clk_load (clk_load),
    .rst      (rst),
    .push_i   (bus.freq_valid),
    .din_i    (dec.sym),
    .pop_i    (pop),
    .dout_o   (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Serializer: high pair on the pop edge, low pair next, chain without a gap.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_LO: begin
        if (pop) begin
          sym_d   = head;
          data_d  = head[3:2];
          valid_d = 1'b1;
          state_d = ST_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HI: begin
        data_d  = sym_q[1:0];
        valid_d = 1'b1;
        state_d = ST_LO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Diagnostics: sticky overflow and saturating off-grid count; clear wins.
  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    if (bus.clr_stat) begin
      ovf_d = 1'b0;
      err_d = '0;
    end else begin
      if (drop) ovf_d = 1'b1;
      if (bus.freq_valid && dec.off_grid && (err_q != {ERR_W{1'b1}}))
        err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  // State and output registers; reset abandons any symbol in flight.
  always_ff @(posedge clk_load or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bus.dataout    = data_q;
  assign bus.dout_valid = valid_q;
  assign bus.sym_out    = sym_q;
  assign bus.overflow   = ovf_q;
  assign bus.err_cnt    = err_q;

endmodule
